// File: rtl/accbuf_pkg.sv
// Shared types and header packing for the accbuf read-back path.
package accbuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] ACCBUF_HDR_MAGIC = 16'hACCB;
  localparam int unsigned HDR_CNT_W        = 33;

  // Header beat: magic, zero pad, then the entry count zero-extended to 33 bits.
  function automatic logic [63:0] pack_hdr(input logic [HDR_CNT_W-1:0] cnt);
    return {ACCBUF_HDR_MAGIC, 15'd0, cnt};
  endfunction

endpackage

// File: rtl/accbuf_rd_fifo.sv
// Small synchronous FIFO buffering BRAM returns ahead of the output stream.
module accbuf_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  // Head reads as zero while empty so the stream data is clean between drains.
  assign head   = (count != '0) ? mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
      end
      if (do_pop) begin
        rptr <= (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/accbuf_reader.sv
// Drains one accbuf channel through the BRAM read port into a valid/ready stream.
// Optional header beat per drain when ACCBUF_READER_HDR_EN is defined.
module accbuf_reader
  import accbuf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   wr_count,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

  state_t                  state, state_nxt;
  logic [READ_LATENCY-1:0] inflight;
  logic [CNT_W-1:0]        total;
  logic [CNT_W-1:0]        issue_left;
  logic [CNT_W-1:0]        next_addr;
  logic [CNT_W-1:0]        push_idx;
  logic                    issue;
  logic                    beat;
  logic                    drain_end;
  logic                    credit_ok;
  logic [OCC_W-1:0]        occ;
  logic                    hdr_push;
  logic                    hdr_tlast;
  logic [DATA_WIDTH-1:0]   hdr_word;
  logic                    data_push;
  logic                    data_tlast;
  logic                    fifo_push;
  logic [DATA_WIDTH:0]     fifo_din;
  logic [DATA_WIDTH:0]     fifo_head;
  logic [FCNT_W-1:0]       fifo_count;

`ifdef ACCBUF_READER_HDR_EN
  assign hdr_push  = (state == IDLE) && start;
  assign hdr_tlast = (wr_count == '0);
  assign hdr_word  = DATA_WIDTH'(pack_hdr(HDR_CNT_W'(wr_count)));
  assign drain_end = beat && tlast;
`else
  assign hdr_push  = 1'b0;
  assign hdr_tlast = 1'b0;
  assign hdr_word  = '0;
  // An empty drain has no beats to wait for.
  assign drain_end = (beat && tlast) || (total == '0);
`endif

  assign tvalid = (fifo_count != '0);
  assign tdata  = fifo_head[DATA_WIDTH-1:0];
  assign tlast  = fifo_head[DATA_WIDTH];
  assign beat   = tvalid && tready;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Occupancy after this edge before any new issue: buffered + in flight + header - pop.
  assign occ       = OCC_W'(fifo_count) + OCC_W'($countones(inflight)) + OCC_W'(rd_en)
                   + OCC_W'(hdr_push) - OCC_W'(beat);
  assign credit_ok = (occ < OCC_W'(FIFO_DEPTH));

  assign data_push  = inflight[READ_LATENCY-1];
  assign data_tlast = (push_idx == total - CNT_W'(1));
  assign fifo_push  = data_push || hdr_push;
  assign fifo_din   = hdr_push ? {hdr_tlast, hdr_word} : {data_tlast, rd_data};

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // Zero-length drains pass through DRAIN so done lands two cycles after start.
          if (wr_count == '0) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = READ;
            issue     = credit_ok;
          end
        end
      end
      READ: begin
        if (issue_left == '0) state_nxt = DRAIN;
        else                  issue     = credit_ok;
      end
      DRAIN: begin
        if (drain_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      total      <= '0;
      issue_left <= '0;
      next_addr  <= '0;
      push_idx   <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= (inflight << 1) | READ_LATENCY'(rd_en);
      rd_en    <= issue;
      if (state == IDLE && start) begin
        total      <= wr_count;
        issue_left <= wr_count - CNT_W'(issue);
        next_addr  <= CNT_W'(issue);
        rd_addr    <= '0;
        push_idx   <= '0;
      end else begin
        if (issue) begin
          rd_addr    <= ADDR_WIDTH'(next_addr);
          next_addr  <= next_addr + CNT_W'(1);
          issue_left <= issue_left - CNT_W'(1);
        end
        if (data_push) push_idx <= push_idx + CNT_W'(1);
      end
    end
  end

  accbuf_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (beat),
    .head      (fifo_head),
    .count     (fifo_count)
  );

endmodule
